uart_tx_fifo_reader: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_tx_fifo_reader.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and baud divisor helper
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per serial bit, rounded to the nearest integer.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - wrapping bit-period counter with one-cycle tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tick
);

    assign o_tick = (o_count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            o_count <= '0;
        end else if (o_tick) begin
            o_count <= '0;
        end else begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - pops a fifo and sends each word as an async serial frame
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_stb,
    input  logic                  i_enable,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_byte_done
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0]      bit_idx;
    logic                  stop_cnt;
    logic [CNT_W-1:0]      baud_cnt;
    logic                  baud_tick;
    logic                  can_start;
    logic                  last_stop;

    assign can_start = i_enable && !i_fifo_empty;
    assign last_stop = (STOP_BITS == 1) || stop_cnt;

    // Held clear while idle so every frame starts its first bit at count 0.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(state == ST_IDLE),
        .o_count(baud_cnt),
        .o_tick (baud_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            shift_reg     <= '0;
            bit_idx       <= '0;
            stop_cnt      <= 1'b0;
            o_tx          <= UART_IDLE_LEVEL;
            o_busy        <= 1'b0;
            o_fifo_rd_stb <= 1'b0;
            o_byte_done   <= 1'b0;
        end else begin
            o_fifo_rd_stb <= 1'b0;
            o_byte_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (can_start) begin
                        shift_reg     <= i_fifo_data;
                        bit_idx       <= '0;
                        state         <= ST_START;
                        o_tx          <= 1'b0;
                        o_busy        <= 1'b1;
                        o_fifo_rd_stb <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state <= ST_DATA;
                        o_tx  <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            state    <= ST_STOP;
                            stop_cnt <= 1'b0;
                            o_tx     <= UART_IDLE_LEVEL;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            o_tx      <= shift_reg[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Registered pulse: set one cycle early so it lands on the last stop cycle.
                    if (last_stop && baud_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
                        o_byte_done <= 1'b1;
                    end
                    if (baud_tick) begin
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else if (can_start) begin
                            shift_reg     <= i_fifo_data;
                            bit_idx       <= '0;
                            state         <= ST_START;
                            o_tx          <= 1'b0;
                            o_fifo_rd_stb <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - randomized bench against a frame-position reference model
module tb_uart_tx_fifo_reader;

    localparam int DW     = 8;
    localparam int CPB    = 4;
    localparam int FRAME1 = (1 + DW + 1) * CPB;
    localparam int FRAME2 = (1 + DW + 2) * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_reset;
    logic          i_enable;
    logic          i_fifo_empty;
    logic [DW-1:0] i_fifo_data;
    logic          rd_stb, tx, busy, byte_done;

    logic          empty2;
    logic [DW-1:0] data2;
    logic          rd_stb2, tx2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int stb_cycles[$];
    logic [DW-1:0] q[$];

    int            m_pos  = 0;
    logic [DW-1:0] m_word = '0;

    uart_tx_fifo_reader #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_stb(rd_stb),
        .i_enable     (i_enable),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_byte_done  (byte_done)
    );

    uart_tx_fifo_reader #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_data  (data2),
        .i_fifo_empty (empty2),
        .o_fifo_rd_stb(rd_stb2),
        .i_enable     (i_enable),
        .o_tx         (tx2),
        .o_busy       (busy2),
        .o_byte_done  (done2)
    );

    // Reference: position within the current frame (0 = idle, 1..FRAME1 = frame cycle).
    always @(posedge clk) begin
        if (i_reset) begin
            m_pos <= 0;
        end else if (m_pos == 0 || m_pos == FRAME1) begin
            if (i_enable && !i_fifo_empty) begin
                m_pos  <= 1;
                m_word <= i_fifo_data;
            end else begin
                m_pos <= 0;
            end
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    function automatic logic exp_tx(input int pos, input logic [DW-1:0] w);
        int slot;
        if (pos == 0) return 1'b1;
        slot = (pos - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return w[slot-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        i_fifo_empty = (q.size() == 0);
        i_fifo_data  = (q.size() == 0) ? '0 : q[0];
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check("tx", tx, exp_tx(m_pos, m_word));
        check("busy", busy, m_pos != 0);
        check("rd_stb", rd_stb, m_pos == 1);
        check("byte_done", byte_done, m_pos == FRAME1);
        if (busy) busy_cnt++;
        if (rd_stb) begin
            stb_cycles.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
        end
        refresh();
    endtask

    initial begin
        int gap;
        int guard;
        logic found;

        i_reset  = 1'b1;
        i_enable = 1'b0;
        empty2   = 1'b1;
        data2    = '0;
        refresh();

        repeat (3) tick();
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        i_reset = 1'b0;
        repeat (2) tick();

        // Single byte
        i_enable = 1'b1;
        q.push_back(8'hA5);
        refresh();
        stb_cycles.delete();
        busy_cnt = 0;
        repeat (FRAME1 + 4) tick();
        check("single_pops", stb_cycles.size(), 1);
        check("single_busy_len", busy_cnt, FRAME1);
        check("single_q_empty", q.size(), 0);

        // Back-to-back
        q.push_back(8'h00);
        q.push_back(8'hFF);
        refresh();
        stb_cycles.delete();
        busy_cnt = 0;
        repeat (2 * FRAME1 + 4) tick();
        check("b2b_pops", stb_cycles.size(), 2);
        gap = (stb_cycles.size() == 2) ? stb_cycles[1] - stb_cycles[0] : -1;
        check("b2b_gap", gap, FRAME1);
        check("b2b_busy_len", busy_cnt, 2 * FRAME1);

        // Enable gating
        i_enable = 1'b0;
        q.push_back(8'h5A);
        q.push_back(8'h33);
        refresh();
        stb_cycles.delete();
        repeat (100) tick();
        check("gate_no_pop", stb_cycles.size(), 0);
        check("gate_q_kept", q.size(), 2);
        i_enable = 1'b1;
        guard = 0;
        while (m_pos != 17 && guard < 50) begin
            tick();
            guard++;
        end
        check("gate_reach_bit3", m_pos, 17);
        i_enable = 1'b0;
        repeat (FRAME1 + 20) tick();
        check("gate_one_pop", stb_cycles.size(), 1);
        check("gate_q_left", q.size(), 1);
        q.delete();
        refresh();

        // Reset mid-frame
        i_enable = 1'b1;
        q.push_back(8'h3C);
        q.push_back(8'h81);
        refresh();
        stb_cycles.delete();
        guard = 0;
        while (m_pos != 21 && guard < 50) begin
            tick();
            guard++;
        end
        check("rst_reach_bit4", m_pos, 21);
        i_reset = 1'b1;
        tick();
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        i_reset = 1'b0;
        repeat (FRAME1 + 5) tick();
        check("rst_pops", stb_cycles.size(), 2);
        check("rst_q_empty", q.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) i_enable = !i_enable;
            if (q.size() < 4 && $urandom_range(0, 7) == 0) q.push_back(8'($urandom));
            refresh();
            tick();
        end
        i_reset  = 1'b0;
        i_enable = 1'b0;
        repeat (FRAME1 + 2) tick();
        q.delete();
        refresh();
        i_enable = 1'b1;
        tick();

        // Two stop bits
        empty2 = 1'b0;
        data2  = 8'h55;
        found  = 1'b0;
        guard  = 0;
        while (!found && guard < 10) begin
            tick();
            found = rd_stb2;
            guard++;
        end
        empty2 = 1'b1;
        check("sb2_stb_seen", found, 1'b1);
        check("sb2_tx_p1", tx2, exp_tx(1, 8'h55));
        for (int p = 2; p <= FRAME2; p++) begin
            tick();
            check("sb2_tx", tx2, exp_tx(p, 8'h55));
            check("sb2_busy", busy2, 1'b1);
            check("sb2_done", done2, p == FRAME2);
            check("sb2_stb", rd_stb2, 1'b0);
        end
        tick();
        check("sb2_idle_busy", busy2, 1'b0);
        check("sb2_idle_tx", tx2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
